// File: rtl/vx_local_mem_pkg.sv
// Shared types and constants for the Vortex local line-memory arbiter.
package vx_local_mem_pkg;

    localparam int LINE_BITS = 512;
    localparam int LANES     = LINE_BITS / 32;
    localparam int LANE_W    = 4;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_VX,
        GRANT_HOST
    } grant_t;

    typedef enum logic {
        HOST_IDLE,
        HOST_ACK
    } host_state_t;

endpackage

// File: rtl/vx_rr_arb2.sv
// Two-way round-robin arbiter: on contention the side that was not granted last wins.
module vx_rr_arb2
    import vx_local_mem_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   req_vx_i,
    input  logic   req_host_i,
    output grant_t grant_o
);

    grant_t last_q, last_d;
    grant_t grant_c;

    always_comb begin
        grant_c = GRANT_NONE;
        if (req_vx_i && req_host_i) begin
            grant_c = (last_q == GRANT_VX) ? GRANT_HOST : GRANT_VX;
        end else if (req_vx_i) begin
            grant_c = GRANT_VX;
        end else if (req_host_i) begin
            grant_c = GRANT_HOST;
        end
        last_d = (grant_c == GRANT_NONE) ? last_q : grant_c;
    end

    // Host counts as last winner out of reset so Vortex wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= GRANT_HOST;
        end else begin
            last_q <= last_d;
        end
    end

    assign grant_o = grant_c;

endmodule

// File: rtl/vx_local_mem_arbiter.sv
// Shares one single-ported line RAM between the Vortex memory port and host word accesses,
// returning tagged Vortex read responses and acknowledging host accesses through gb_busy.
module vx_local_mem_arbiter
    import vx_local_mem_pkg::*;
#(
    parameter int          ADDR_W    = 26,
    parameter int          DATA_W    = 512,
    parameter int          TAG_W     = 56,
    parameter int          MEM_LINES = 65536,
    parameter logic [31:0] BAD_DATA  = 32'hBAD1BAD1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_req_valid,
    input  logic                mem_req_rw,
    input  logic [DATA_W/8-1:0] mem_req_byteen,
    input  logic [ADDR_W-1:0]   mem_req_addr,
    input  logic [DATA_W-1:0]   mem_req_data,
    input  logic [TAG_W-1:0]    mem_req_tag,
    output logic                mem_req_ready,
    output logic                mem_rsp_valid,
    output logic [DATA_W-1:0]   mem_rsp_data,
    output logic [TAG_W-1:0]    mem_rsp_tag,
    input  logic                mem_rsp_ready,
    input  logic [31:0]         gb_addr,
    input  logic                gb_ren,
    input  logic                gb_wen,
    input  logic [31:0]         gb_wdata,
    input  logic [3:0]          gb_byte_en,
    output logic [31:0]         gb_rdata,
    output logic                gb_busy,
    output logic                ram_en,
    output logic                ram_wen,
    output logic [DATA_W/8-1:0] ram_byteen,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic                tb_addr_out_of_bounds
);

    localparam int BE_W = DATA_W / 8;

    host_state_t        host_state_q, host_state_d;
    logic               host_rd_q, host_rd_d;
    logic               host_oob_q, host_oob_d;
    logic [LANE_W-1:0]  host_lane_q, host_lane_d;
    logic               rd_inflight_q, rd_inflight_d;
    logic               rd_oob_q, rd_oob_d;
    logic [TAG_W-1:0]   rd_tag_q, rd_tag_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic               oob_flag_q, oob_flag_d;

    logic [ADDR_W-1:0]  host_line;
    logic [LANE_W-1:0]  host_lane;
    logic               host_oob, vx_oob;
    logic               vx_elig, host_elig;
    grant_t             grant;

    assign host_line = gb_addr[ADDR_W+5:6];
    assign host_lane = gb_addr[5:2];
    assign host_oob  = 64'(host_line) >= 64'(MEM_LINES);
    assign vx_oob    = 64'(mem_req_addr) >= 64'(MEM_LINES);

    // Requests are masked while reset is held so no grant can leak out combinationally.
    assign vx_elig   = reset & mem_req_valid & ~rd_inflight_q & (~rsp_valid_q | mem_rsp_ready);
    assign host_elig = reset & (gb_ren | gb_wen) & (host_state_q == HOST_IDLE);

    vx_rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req_vx_i   (vx_elig),
        .req_host_i (host_elig),
        .grant_o    (grant)
    );

    assign mem_req_ready = (grant == GRANT_VX);

    always_comb begin
        ram_en     = 1'b0;
        ram_wen    = 1'b0;
        ram_byteen = '0;
        ram_addr   = '0;
        ram_wdata  = '0;
        case (grant)
            GRANT_VX: begin
                ram_en     = ~vx_oob;
                ram_wen    = mem_req_rw;
                ram_byteen = mem_req_byteen;
                ram_addr   = mem_req_addr;
                ram_wdata  = mem_req_data;
            end
            GRANT_HOST: begin
                ram_en     = ~host_oob;
                ram_wen    = gb_wen;
                ram_byteen = BE_W'(gb_byte_en) << {host_lane, 2'b00};
                ram_addr   = host_line;
                ram_wdata  = {(DATA_W/32){gb_wdata}};
            end
            default: ;
        endcase
    end

    always_comb begin
        host_state_d = host_state_q;
        host_rd_d    = host_rd_q;
        host_oob_d   = host_oob_q;
        host_lane_d  = host_lane_q;
        gb_busy      = 1'b1;
        gb_rdata     = '0;
        case (host_state_q)
            HOST_IDLE: begin
                if (grant == GRANT_HOST) begin
                    host_state_d = HOST_ACK;
                    host_rd_d    = ~gb_wen;
                    host_oob_d   = host_oob;
                    host_lane_d  = host_lane;
                end
            end
            HOST_ACK: begin
                gb_busy      = 1'b0;
                host_state_d = HOST_IDLE;
                if (host_rd_q) begin
                    gb_rdata = host_oob_q ? BAD_DATA : ram_rdata[{host_lane_q, 5'b0} +: 32];
                end
            end
            default: host_state_d = HOST_IDLE;
        endcase
    end

    always_comb begin
        rd_inflight_d = (grant == GRANT_VX) & ~mem_req_rw;
        rd_oob_d      = rd_oob_q;
        rd_tag_d      = rd_tag_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_tag_d     = rsp_tag_q;
        oob_flag_d    = oob_flag_q;

        if (grant == GRANT_VX && !mem_req_rw) begin
            rd_oob_d = vx_oob;
            rd_tag_d = mem_req_tag;
        end
        // An accepted read implies the previous response was already drained.
        if (rd_inflight_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_oob_q ? '0 : ram_rdata;
            rsp_tag_d   = rd_tag_q;
        end else if (rsp_valid_q && mem_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if ((grant == GRANT_VX && vx_oob) || (grant == GRANT_HOST && host_oob)) begin
            oob_flag_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_state_q  <= HOST_IDLE;
            host_rd_q     <= 1'b0;
            host_oob_q    <= 1'b0;
            host_lane_q   <= '0;
            rd_inflight_q <= 1'b0;
            rd_oob_q      <= 1'b0;
            rd_tag_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_tag_q     <= '0;
            oob_flag_q    <= 1'b0;
        end else begin
            host_state_q  <= host_state_d;
            host_rd_q     <= host_rd_d;
            host_oob_q    <= host_oob_d;
            host_lane_q   <= host_lane_d;
            rd_inflight_q <= rd_inflight_d;
            rd_oob_q      <= rd_oob_d;
            rd_tag_q      <= rd_tag_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_tag_q     <= rsp_tag_d;
            oob_flag_q    <= oob_flag_d;
        end
    end

    assign mem_rsp_valid         = rsp_valid_q;
    assign mem_rsp_data          = rsp_data_q;
    assign mem_rsp_tag           = rsp_tag_q;
    assign tb_addr_out_of_bounds = oob_flag_q;

endmodule

// File: tb/tb_vx_local_mem_arbiter.sv
// Self-checking bench: behavioural 1-cycle RAM, response scoreboard, host vector table, corner sequences.
module tb_vx_local_mem_arbiter;

    localparam int          ADDR_W    = 26;
    localparam int          DATA_W    = 512;
    localparam int          TAG_W     = 56;
    localparam int          BE_W      = DATA_W / 8;
    localparam int          MEM_LINES = 16;
    localparam logic [31:0] BAD_DATA  = 32'hBAD1BAD1;

    logic              clk;
    logic              reset;
    logic              mem_req_valid, mem_req_rw, mem_req_ready;
    logic [BE_W-1:0]   mem_req_byteen;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic [TAG_W-1:0]  mem_req_tag;
    logic              mem_rsp_valid, mem_rsp_ready;
    logic [DATA_W-1:0] mem_rsp_data;
    logic [TAG_W-1:0]  mem_rsp_tag;
    logic [31:0]       gb_addr, gb_wdata, gb_rdata;
    logic              gb_ren, gb_wen, gb_busy;
    logic [3:0]        gb_byte_en;
    logic              ram_en, ram_wen;
    logic [BE_W-1:0]   ram_byteen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              oob_flag;

    int checks = 0;
    int errors = 0;

    vx_local_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .MEM_LINES(MEM_LINES), .BAD_DATA(BAD_DATA)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_ready(mem_rsp_ready),
        .gb_addr(gb_addr), .gb_ren(gb_ren), .gb_wen(gb_wen), .gb_wdata(gb_wdata),
        .gb_byte_en(gb_byte_en), .gb_rdata(gb_rdata), .gb_busy(gb_busy),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_byteen(ram_byteen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .tb_addr_out_of_bounds(oob_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Initial line contents: each lane word is unique so lane-select mistakes are visible.
    function automatic logic [DATA_W-1:0] pat(input int line);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int k = 0; k < DATA_W / 32; k++) begin
            v[k*32 +: 32] = 32'hC0DE_0000 | (32'(line & 255) << 8) | 32'(k);
        end
        return v;
    endfunction

    logic [DATA_W-1:0] ram_mem [MEM_LINES];
    bit                ram_inited;

    always @(posedge clk) begin
        logic [DATA_W-1:0] line_v;
        if (!ram_inited) begin
            for (int i = 0; i < MEM_LINES; i++) ram_mem[i] = pat(i);
            ram_inited = 1'b1;
        end
        if (ram_en) begin
            line_v = ram_mem[ram_addr[3:0]];
            ram_rdata <= line_v;
            if (ram_wen) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (ram_byteen[b]) line_v[b*8 +: 8] = ram_wdata[b*8 +: 8];
                end
                ram_mem[ram_addr[3:0]] = line_v;
            end
        end
    end

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } rsp_t;

    rsp_t sb_q[$];

    always @(negedge clk) begin
        rsp_t e;
        if (reset) begin
            if (mem_rsp_valid && mem_rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: response tag %0h, expected no response", mem_rsp_tag);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_data", mem_rsp_data, e.data);
                    check("sb_tag", DATA_W'(mem_rsp_tag), DATA_W'(e.tag));
                end
            end
            if (mem_req_valid && mem_req_ready && !mem_req_rw) begin
                e.tag  = mem_req_tag;
                e.data = (int'(mem_req_addr) >= MEM_LINES) ? '0 : pat(int'(mem_req_addr));
                sb_q.push_back(e);
            end
        end
    end

    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sb_empty(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d responses outstanding, expected 0", name, sb_q.size());
        end
    endtask

    task automatic vx_read(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t, output logic en_seen);
        logic acc;
        acc = 1'b0;
        en_seen = 1'b0;
        mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = a; mem_req_tag = t;
        mem_req_byteen = '1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req_ready) begin
                en_seen = ram_en;
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL vx_accept_timeout: tag %0h not accepted, expected acceptance", t);
        end
        drive_point();
        mem_req_valid = 1'b0;
    endtask

    task automatic host_op(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                           output logic en_seen, output logic [BE_W-1:0] be_seen,
                           output logic [31:0] rd, output logic done);
        gb_addr = a; gb_wdata = wd; gb_byte_en = be; gb_wen = wr; gb_ren = ~wr;
        done = 1'b0; rd = '0;
        @(negedge clk);
        en_seen = ram_en;
        be_seen = ram_byteen;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!gb_busy) begin
                rd = gb_rdata;
                done = 1'b1;
                break;
            end
        end
        drive_point();
        gb_wen = 1'b0; gb_ren = 1'b0;
    endtask

    typedef struct {
        logic            wr;
        logic [31:0]     addr;
        logic [31:0]     wdata;
        logic [3:0]      be;
        logic            exp_en;
        logic [BE_W-1:0] exp_be;
        logic [31:0]     exp_rd;
        logic            exp_flag;
    } hv_t;

    hv_t vec[9];

    initial begin
        logic            en_s, done_s, prev_host;
        logic [BE_W-1:0] be_s;
        logic [31:0]     rd_s;
        int              exp_g, obs_g;

        vec[0] = '{1'b1, 32'h0000_0048, 32'hDEADBEEF, 4'hF, 1'b1, 64'h0000_0000_0000_0F00, 32'h0, 1'b0};
        vec[1] = '{1'b0, 32'h0000_0048, 32'h0,        4'hF, 1'b1, 64'h0, 32'hDEADBEEF, 1'b0};
        vec[2] = '{1'b1, 32'h0000_0084, 32'h12345678, 4'h3, 1'b1, 64'h0000_0000_0000_0030, 32'h0, 1'b0};
        vec[3] = '{1'b0, 32'h0000_0084, 32'h0,        4'hF, 1'b1, 64'h0, 32'hC0DE5678, 1'b0};
        vec[4] = '{1'b0, 32'h0000_003C, 32'h0,        4'hF, 1'b1, 64'h0, 32'hC0DE000F, 1'b0};
        vec[5] = '{1'b0, 32'h0000_0200, 32'h0,        4'hF, 1'b1, 64'h0, 32'hA5A50001, 1'b0};
        vec[6] = '{1'b1, 32'h0000_0400, 32'h11111111, 4'hF, 1'b0, 64'h0, 32'h0, 1'b1};
        vec[7] = '{1'b0, 32'h0000_0404, 32'h0,        4'hF, 1'b0, 64'h0, BAD_DATA, 1'b1};
        vec[8] = '{1'b0, 32'h0000_0048, 32'h0,        4'hF, 1'b1, 64'h0, 32'hDEADBEEF, 1'b1};

        reset = 1'b0;
        mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_byteen = '1; mem_req_addr = '0;
        mem_req_data = '0; mem_req_tag = '0; mem_rsp_ready = 1'b1;
        gb_addr = '0; gb_ren = 1'b1; gb_wen = 1'b0; gb_wdata = '0; gb_byte_en = '0;

        // Reset held over an edge with both sides requesting: nothing may be granted.
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", DATA_W'(gb_busy), 1);
        check("rst_rsp_valid", DATA_W'(mem_rsp_valid), 0);
        check("rst_ram_en", DATA_W'(ram_en), 0);
        check("rst_req_ready", DATA_W'(mem_req_ready), 0);
        check("rst_flag", DATA_W'(oob_flag), 0);
        check("rst_rdata", DATA_W'(gb_rdata), 0);
        mem_req_valid = 1'b0; gb_ren = 1'b0;
        drive_point();
        reset = 1'b1;

        // Single Vortex read: accept in N, blocked in N+1, response in N+2.
        drive_point();
        mem_req_valid = 1'b1; mem_req_addr = 26'h5; mem_req_tag = 56'h5A;
        @(negedge clk);
        check("rd_ready_n", DATA_W'(mem_req_ready), 1);
        check("rd_ram_en_n", DATA_W'(ram_en), 1);
        check("rd_ram_addr_n", DATA_W'(ram_addr), 5);
        check("rd_ram_wen_n", DATA_W'(ram_wen), 0);
        drive_point();
        @(negedge clk);
        check("rd_ready_n1", DATA_W'(mem_req_ready), 0);
        check("rd_rsp_valid_n1", DATA_W'(mem_rsp_valid), 0);
        drive_point();
        mem_req_valid = 1'b0;
        @(negedge clk);
        check("rd_rsp_valid_n2", DATA_W'(mem_rsp_valid), 1);
        check("rd_rsp_tag_n2", DATA_W'(mem_rsp_tag), 56'h5A);
        check("rd_rsp_data_n2", mem_rsp_data, pat(5));
        @(negedge clk);
        check("rd_rsp_drained", DATA_W'(mem_rsp_valid), 0);
        wait_sb_empty("rd_sb_empty");

        // Contention from reset: Vortex and host request every cycle with zero byte enables.
        drive_point();
        reset = 1'b0;
        mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_addr = 26'h3; mem_req_byteen = '0;
        gb_addr = 32'h0000_00C0; gb_wen = 1'b1; gb_byte_en = 4'h0;
        drive_point();
        reset = 1'b1;
        prev_host = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_g = (c % 2 == 0) ? 1 : 2;
            obs_g = mem_req_ready ? 1 : (ram_en ? 2 : 0);
            check("cont_grant", DATA_W'(obs_g), DATA_W'(exp_g));
            check("cont_busy", DATA_W'(gb_busy), prev_host ? 0 : 1);
            prev_host = (exp_g == 2);
        end
        drive_point();
        mem_req_valid = 1'b0; mem_req_rw = 1'b0; gb_wen = 1'b0;
        drive_point();

        // Backpressure: response A stalls while read B waits; the host still gets through.
        mem_rsp_ready = 1'b0;
        vx_read(26'h6, 56'h11, en_s);
        mem_req_valid = 1'b1; mem_req_addr = 26'h7; mem_req_tag = 56'h22;
        fork
            begin
                @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_rsp_valid", DATA_W'(mem_rsp_valid), 1);
                    check("bp_rsp_tag", DATA_W'(mem_rsp_tag), 56'h11);
                    check("bp_rsp_data", mem_rsp_data, pat(6));
                    check("bp_req_ready", DATA_W'(mem_req_ready), 0);
                end
            end
            begin
                host_op(1'b1, 32'h0000_0200, 32'hA5A50001, 4'hF, en_s, be_s, rd_s, done_s);
                check("bp_host_done", DATA_W'(done_s), 1);
                check("bp_host_byteen", DATA_W'(be_s), 64'hF);
            end
        join
        drive_point();
        mem_rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_accept", DATA_W'(mem_req_ready), 1);
        drive_point();
        mem_req_valid = 1'b0;
        wait_sb_empty("bp_sb_empty");

        // Reset while a read is in flight: the response must never appear.
        drive_point();
        vx_read(26'h9, 56'h33, en_s);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", DATA_W'(gb_busy), 1);
        check("mid_rst_rsp_valid", DATA_W'(mem_rsp_valid), 0);
        check("mid_rst_ram_en", DATA_W'(ram_en), 0);
        drive_point();
        reset = 1'b1;
        sb_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", DATA_W'(mem_rsp_valid), 0);
        end
        drive_point();

        // Host vector table, ending with out-of-bounds and sticky-flag cases.
        for (int v = 0; v < 9; v++) begin
            host_op(vec[v].wr, vec[v].addr, vec[v].wdata, vec[v].be, en_s, be_s, rd_s, done_s);
            check($sformatf("hv%0d_done", v), DATA_W'(done_s), 1);
            check($sformatf("hv%0d_ram_en", v), DATA_W'(en_s), DATA_W'(vec[v].exp_en));
            if (vec[v].wr && vec[v].exp_en) check($sformatf("hv%0d_byteen", v), DATA_W'(be_s), DATA_W'(vec[v].exp_be));
            if (!vec[v].wr) check($sformatf("hv%0d_rdata", v), DATA_W'(rd_s), DATA_W'(vec[v].exp_rd));
            check($sformatf("hv%0d_flag", v), DATA_W'(oob_flag), DATA_W'(vec[v].exp_flag));
        end

        // Out-of-bounds Vortex read: no RAM strobe, zero data with the right tag.
        vx_read(26'h10, 56'h5A, en_s);
        check("vx_oob_ram_en", DATA_W'(en_s), 0);
        wait_sb_empty("vx_oob_sb_empty");
        check("vx_oob_flag", DATA_W'(oob_flag), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
